// File: rtl/crc_ctrl_pkg.sv
// Shared types and constants for the CRC engine sequencer.
// State encoding, mode select values and a small sizing helper.
package crc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/crc_shift_counter.sv
// Loadable down-counter for the shift phase.
// Load wins over decrement; the count saturates at zero.
module crc_shift_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/crc_engine_arbiter.sv
// Round-robin sequencer sharing one CRC shift engine
// between the memory write (encode) and read (decode) paths.
module crc_engine_arbiter
    import crc_ctrl_pkg::*;
#(
    parameter int WR_SHIFT_CYCLES = 32,
    parameter int RD_SHIFT_CYCLES = 40,
    parameter int CNT_W =
        $clog2(max_int(WR_SHIFT_CYCLES, RD_SHIFT_CYCLES))
) (
    input  logic clk,
    input  logic rst,
    input  logic write,
    input  logic read,
    input  logic crc_zero,
    output logic crc_load_en,
    output logic crc_shift_en,
    output logic crc_mode,
    output logic write_mem_en,
    output logic read_data_valid,
    output logic read_error,
    output logic write_busy,
    output logic read_busy
);

    state_t state, state_nx;
    logic   pending_wr, pending_rd;
    logic   last_grant, active_mode;
    logic   acc_wr, acc_rd;
    logic   req_wr, req_rd;
    logic   arb_slot;
    logic   grant_wr, grant_rd, grant;
    logic   cnt_zero;
    logic   engaged;
    logic [CNT_W-1:0] load_val;

    assign engaged    = (state != IDLE);
    assign write_busy = pending_wr | (engaged & (active_mode == MODE_ENC));
    assign read_busy  = pending_rd | (engaged & (active_mode == MODE_DEC));

    assign acc_wr = write & ~write_busy;
    assign acc_rd = read & ~read_busy;
    assign req_wr = pending_wr | acc_wr;
    assign req_rd = pending_rd | acc_rd;

    // On a tie the side opposite the previous grant wins.
    assign arb_slot = (state == IDLE) || (state == DONE);
    assign grant_wr = arb_slot & req_wr &
                      (~req_rd | (last_grant == MODE_DEC));
    assign grant_rd = arb_slot & req_rd &
                      (~req_wr | (last_grant == MODE_ENC));
    assign grant    = grant_wr | grant_rd;

    assign load_val = grant_wr ? CNT_W'(WR_SHIFT_CYCLES - 1)
                               : CNT_W'(RD_SHIFT_CYCLES - 1);

    crc_shift_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (grant),
        .load_val(load_val),
        .dec     (state == SHIFT),
        .zero    (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pending_wr  <= 1'b0;
            pending_rd  <= 1'b0;
            last_grant  <= MODE_DEC;
            active_mode <= MODE_ENC;
        end else begin
            state <= state_nx;
            if (grant_wr) begin
                pending_wr <= 1'b0;
            end else if (acc_wr) begin
                pending_wr <= 1'b1;
            end
            if (grant_rd) begin
                pending_rd <= 1'b0;
            end else if (acc_rd) begin
                pending_rd <= 1'b1;
            end
            if (grant) begin
                last_grant  <= grant_rd;
                active_mode <= grant_rd;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (grant) state_nx = LOAD;
            LOAD:  state_nx = SHIFT;
            SHIFT: if (cnt_zero) state_nx = DONE;
            DONE:  state_nx = grant ? LOAD : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        crc_load_en     = (state == LOAD);
        crc_shift_en    = (state == SHIFT);
        crc_mode        = engaged & active_mode;
        write_mem_en    = (state == DONE) & (active_mode == MODE_ENC);
        read_data_valid = (state == DONE) & (active_mode == MODE_DEC);
        read_error      = read_data_valid & ~crc_zero;
    end

endmodule

// File: tb/tb_crc_engine_arbiter.sv
// Randomised and directed bench for crc_engine_arbiter against
// a job/phase reference model of the shared engine.
module tb_crc_engine_arbiter;

    localparam int WR_N = 32;
    localparam int RD_N = 40;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic write = 1'b0;
    logic read = 1'b0;
    logic crc_zero = 1'b1;
    logic crc_load_en, crc_shift_en, crc_mode;
    logic write_mem_en, read_data_valid, read_error;
    logic write_busy, read_busy;

    crc_engine_arbiter #(
        .WR_SHIFT_CYCLES(WR_N),
        .RD_SHIFT_CYCLES(RD_N)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .write          (write),
        .read           (read),
        .crc_zero       (crc_zero),
        .crc_load_en    (crc_load_en),
        .crc_shift_en   (crc_shift_en),
        .crc_mode       (crc_mode),
        .write_mem_en   (write_mem_en),
        .read_data_valid(read_data_valid),
        .read_error     (read_error),
        .write_busy     (write_busy),
        .read_busy      (read_busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: one engine job (mode + phase since LOAD) and two pending flags.
    bit m_job, m_mode, m_pw, m_pr, m_last;
    int m_phase;

    int cyc = 0;
    int t0;
    int load_cnt, first_load, last_load, shifts;
    int wme_cnt, wme_at, rdv_cnt, rdv_at, rerr_cnt, rerr_at;

    function automatic void model_reset();
        m_job = 0; m_mode = 0; m_pw = 0; m_pr = 0;
        m_last = 1; m_phase = 0;
    endfunction

    function automatic logic [7:0] model_out();
        int  n;
        bit  ld, sh, dn, md;
        n  = m_mode ? RD_N : WR_N;
        ld = m_job && (m_phase == 0);
        sh = m_job && (m_phase >= 1) && (m_phase <= n);
        dn = m_job && (m_phase == n + 1);
        md = m_job && m_mode;
        return {ld, sh, md, dn && !m_mode, dn && m_mode,
                dn && m_mode && !crc_zero,
                m_pw | (m_job & !m_mode), m_pr | (m_job & m_mode)};
    endfunction

    function automatic void model_edge(bit w, bit r);
        int n;
        bit wb, rb, qw, qr, free, gw, gr;
        n    = m_mode ? RD_N : WR_N;
        wb   = m_pw | (m_job & !m_mode);
        rb   = m_pr | (m_job & m_mode);
        qw   = m_pw | (w & !wb);
        qr   = m_pr | (r & !rb);
        free = !m_job || (m_phase == n + 1);
        gw = 0; gr = 0;
        if (free) begin
            if (qw && qr) begin
                if (m_last) gw = 1; else gr = 1;
            end else begin
                gw = qw; gr = qr;
            end
        end
        if (gw || gr) begin
            m_job = 1; m_mode = gr; m_phase = 0; m_last = gr;
        end else if (m_job) begin
            if (m_phase == n + 1) m_job = 0;
            else m_phase++;
        end
        m_pw = gw ? 1'b0 : qw;
        m_pr = gr ? 1'b0 : qr;
    endfunction

    function automatic logic [7:0] dut_vec();
        return {crc_load_en, crc_shift_en, crc_mode, write_mem_en,
                read_data_valid, read_error, write_busy, read_busy};
    endfunction

    task automatic check(input string name);
        logic [7:0] d, m;
        d = dut_vec();
        m = model_out();
        vectors++;
        if (d !== m) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%b expected=%b",
                     name, cyc, d, m);
        end
    endtask

    task automatic expect_lit(input string name, input int got,
                              input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic mark();
        t0 = cyc;
        load_cnt = 0; first_load = -1; last_load = -1; shifts = 0;
        wme_cnt = 0; wme_at = -1; rdv_cnt = 0; rdv_at = -1;
        rerr_cnt = 0; rerr_at = -1;
    endtask

    task automatic cycle(input bit w, input bit r, input bit z);
        int rel;
        write = w; read = r; crc_zero = z;
        @(posedge clk);
        cyc++;
        if (rst) model_edge(w, r);
        #1;
        check("cycle");
        rel = cyc - t0;
        if (crc_load_en) begin
            load_cnt++;
            if (first_load < 0) first_load = rel;
            last_load = rel;
        end
        if (crc_shift_en) shifts++;
        if (write_mem_en) begin wme_cnt++; wme_at = rel; end
        if (read_data_valid) begin rdv_cnt++; rdv_at = rel; end
        if (read_error) begin rerr_cnt++; rerr_at = rel; end
    endtask

    task automatic idle(input int n, input bit z);
        for (int i = 0; i < n; i++) cycle(0, 0, z);
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("async_rst");
        expect_lit("async_rst_outs", int'(dut_vec()), 0);
    endtask

    initial begin
        model_reset();
        mark();

        // Held in reset with both requests asserted.
        for (int i = 0; i < 3; i++) cycle(1, 1, 1);
        expect_lit("rst_outs", int'(dut_vec()), 0);
        rst = 1'b1;
        mark();
        idle(3, 1);
        expect_lit("post_rst_load", load_cnt, 0);

        // Simultaneous pair after reset: write first.
        mark();
        cycle(1, 1, 1);
        idle(85, 1);
        expect_lit("pair1_wme_at", wme_at, 34);
        expect_lit("pair1_rd_load", last_load, 35);
        expect_lit("pair1_rdv_at", rdv_at, 76);
        expect_lit("pair1_shifts", shifts, 72);

        // Single write.
        mark();
        cycle(1, 0, 1);
        idle(40, 1);
        expect_lit("wr_load_at", first_load, 1);
        expect_lit("wr_shifts", shifts, 32);
        expect_lit("wr_wme_at", wme_at, 34);

        // Pair after a write grant: read first.
        mark();
        cycle(1, 1, 1);
        idle(85, 1);
        expect_lit("pair2_rdv_at", rdv_at, 42);
        expect_lit("pair2_wr_load", last_load, 43);
        expect_lit("pair2_wme_at", wme_at, 76);

        // Single read, good and bad CRC.
        mark();
        cycle(0, 1, 1);
        idle(45, 1);
        expect_lit("rd_ok_rdv_at", rdv_at, 42);
        expect_lit("rd_ok_shifts", shifts, 40);
        expect_lit("rd_ok_err", rerr_cnt, 0);
        mark();
        cycle(0, 1, 0);
        idle(45, 0);
        expect_lit("rd_bad_err_at", rerr_at, 42);
        expect_lit("rd_bad_err_cnt", rerr_cnt, 1);

        // Write re-pulsed while busy.
        mark();
        for (int i = 0; i < 80; i++)
            cycle((i == 0) || (i == 5) || (i == 34), 0, 1);
        expect_lit("repulse_wme_cnt", wme_cnt, 1);
        expect_lit("repulse_wme_at", wme_at, 34);
        expect_lit("repulse_loads", load_cnt, 1);

        // Async reset mid-SHIFT with a read pending.
        mark();
        cycle(1, 0, 1);
        while ((cyc - t0) < 20) cycle(0, (cyc - t0) == 3, 1);
        expect_lit("pre_rst_shift", int'(crc_shift_en), 1);
        expect_lit("pre_rst_rbusy", int'(read_busy), 1);
        async_reset();
        idle(2, 1);
        rst = 1'b1;
        mark();
        idle(6, 1);
        expect_lit("post_async_loads", load_cnt, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 1) == 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
